// File: rtl/ram_dump_reader.sv
// RAM read-back engine: walks a word range on the RAM debug read port and
// streams {address, word} pairs out through a valid/ready port, buffering up
// to two words so that no word is ever lost or repeated when the sink stalls.
module ram_dump_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     r_issued;
  logic [ADDR_W:0]     r_accepted;

  // read issued last cycle; its data is on mem_rdata this cycle
  logic                r_rd_vld_p1;
  logic [ADDR_W-1:0]   r_rd_addr_p1;

  // two-entry buffer: head drives the output port, skid catches the word
  // that arrives while the head is stalled
  logic                r_head_vld;
  logic [DATA_W-1:0]   r_head_data;
  logic [ADDR_W-1:0]   r_head_addr;
  logic                r_skid_vld;
  logic [DATA_W-1:0]   r_skid_data;
  logic [ADDR_W-1:0]   r_skid_addr;

  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_occ;
  logic [1:0]          w_occ_after;
  logic [1:0]          w_load;
  logic                w_remain;
  logic                w_mem_ce;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [ADDR_W:0]     w_acc_next;
  logic                w_last_pop;

  assign w_push      = r_rd_vld_p1;
  assign w_pop       = r_head_vld && out_ready;
  assign w_occ       = {1'b0, r_head_vld} + {1'b0, r_skid_vld};
  assign w_occ_after = w_occ - {1'b0, w_pop};
  // reads in flight plus words held once this cycle's pop is taken out
  assign w_load      = {1'b0, r_rd_vld_p1} + w_occ_after;
  assign w_remain    = (r_issued != r_count);
  // issue is combinational so a pop from a full buffer frees a slot at once,
  // which keeps one word per cycle flowing with only two entries
  assign w_mem_ce    = (r_state == S_RUN) && w_remain && (w_load < 2'd2);
  assign w_mem_addr  = r_base + r_issued[ADDR_W-1:0];
  assign w_acc_next  = r_accepted + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last_pop  = w_pop && (w_acc_next == r_count);

  // Control FSM: latches the request, counts issued and accepted words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_base     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_base     <= base_addr;
            r_count    <= word_count;
            r_issued   <= '0;
            r_accepted <= '0;
            if (word_count != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_mem_ce) begin
            r_issued <= r_issued + {{ADDR_W{1'b0}}, 1'b1};
          end
          if (w_pop) begin
            r_accepted <= w_acc_next;
          end
          if (w_last_pop) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: remember which address the RAM is returning next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_addr_p1 <= '0;
    end else begin
      r_rd_vld_p1 <= w_mem_ce;
      if (w_mem_ce) begin
        r_rd_addr_p1 <= w_mem_addr;
      end
    end
  end

  // ---- stage p2: capture returning words into head/skid, refill head on pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_vld  <= 1'b0;
      r_head_data <= '0;
      r_head_addr <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_addr <= '0;
    end else begin
      if (!r_head_vld || w_pop) begin
        if (r_skid_vld) begin
          r_head_vld  <= 1'b1;
          r_head_data <= r_skid_data;
          r_head_addr <= r_skid_addr;
          r_skid_vld  <= w_push;
          if (w_push) begin
            r_skid_data <= mem_rdata;
            r_skid_addr <= r_rd_addr_p1;
          end
        end else if (w_push) begin
          r_head_vld  <= 1'b1;
          r_head_data <= mem_rdata;
          r_head_addr <= r_rd_addr_p1;
        end else begin
          r_head_vld  <= 1'b0;
        end
      end else if (w_push) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= mem_rdata;
        r_skid_addr <= r_rd_addr_p1;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_ce    = w_mem_ce;
  assign mem_addr  = w_mem_addr;
  assign out_valid = r_head_vld;
  assign out_data  = r_head_data;
  assign out_addr  = r_head_addr;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Bench for ram_dump_reader: a RAM model on the debug port, a sink with
// selectable ready patterns, a monitor that logs every issue and accept, and
// a reference that derives the expected word stream from base/count and the
// RAM image.
module tb_ram_dump_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  ram_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .mem_ce(mem_ce),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, garbage on the bus when not reading
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) mem_rdata <= mem_ce ? ram[mem_addr] : DATA_W'($urandom);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                iss_addr_q[$];
  int                iss_cyc_q[$];
  int                obs_addr_q[$];
  logic [DATA_W-1:0] obs_data_q[$];
  int                obs_cyc_q[$];
  int done_cnt = 0, done_cyc = -1, done_busy_err = 0;
  int hold_err = 0, over_err = 0, ov_cyc_cnt = 0, busy_cyc_cnt = 0;
  int outstanding = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (mem_ce) begin
        iss_addr_q.push_back(int'(mem_addr));
        iss_cyc_q.push_back(cyc);
      end
      if (out_valid) ov_cyc_cnt++;
      if (busy) busy_cyc_cnt++;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_addr !== prev_addr))
        hold_err++;
      if (out_valid && out_ready) begin
        obs_addr_q.push_back(int'(out_addr));
        obs_data_q.push_back(out_data);
        obs_cyc_q.push_back(cyc);
      end
      // words issued but not yet accepted never exceed the two buffer slots
      outstanding = outstanding + (mem_ce ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (outstanding > 2) over_err++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) done_busy_err++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_addr  = out_addr;
    end
  end

  // ---------------- sink ----------------
  int mode = 0;
  int acc_limit = 0;
  initial begin
    int k;
    k = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (k % 3 == 0); k++; end
        2: out_ready = 1'($urandom_range(0, 1));
        3: out_ready = (obs_addr_q.size() < acc_limit);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input int b, input int n, output int scyc);
    @(posedge clk);
    #1;
    start      = 1'b1;
    base_addr  = b[ADDR_W-1:0];
    word_count = n[ADDR_W:0];
    @(negedge clk);
    scyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_dump(input string tag, input int b, input int n, input int m,
                          input bit per_word, input int inject);
    int i0, o0, d0, h0, ov0, db0, scyc, bad_iss, bad_obs, e_addr, n_iss, n_obs;
    bit ok;
    i0 = iss_addr_q.size(); o0 = obs_addr_q.size(); d0 = done_cnt;
    h0 = hold_err; ov0 = over_err; db0 = done_busy_err;
    mode = m;
    pulse_start(b, n, scyc);
    if (inject > 0) begin
      repeat (inject) @(negedge clk);
      @(posedge clk);
      #1;
      start = 1'b1; base_addr = ADDR_W'(b + 500); word_count = 11'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(d0, 10000, ok);
    chk({tag, "_done_seen"}, longint'(ok), 1);
    repeat (4) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    n_iss = iss_addr_q.size() - i0;
    n_obs = obs_addr_q.size() - o0;
    chk({tag, "_issued"}, n_iss, n);
    chk({tag, "_accepted"}, n_obs, n);
    bad_iss = 0;
    bad_obs = 0;
    for (int i = 0; i < n; i++) begin
      e_addr = (b + i) % DEPTH;
      if (i < n_iss && iss_addr_q[i0 + i] != e_addr) bad_iss++;
      if (i < n_obs) begin
        if (obs_addr_q[o0 + i] != e_addr || obs_data_q[o0 + i] !== ram[e_addr]) bad_obs++;
        if (per_word) begin
          chk($sformatf("%s_addr%0d", tag, i), obs_addr_q[o0 + i], e_addr);
          chk($sformatf("%s_data%0d", tag, i), obs_data_q[o0 + i], ram[e_addr]);
        end
      end
    end
    chk({tag, "_issue_addr_errs"}, bad_iss, 0);
    chk({tag, "_word_errs"}, bad_obs, 0);
    if (n_iss > 0) chk({tag, "_first_issue_cyc"}, iss_cyc_q[i0], scyc + 1);
    if (n_obs > 0) chk({tag, "_done_after_last"}, done_cyc, obs_cyc_q[o0 + n_obs - 1] + 1);
    if (m == 0 && n_obs == n && n > 0)
      chk({tag, "_back_to_back"}, obs_cyc_q[o0 + n - 1] - obs_cyc_q[o0], n - 1);
    chk({tag, "_hold_errs"}, hold_err - h0, 0);
    chk({tag, "_overissue"}, over_err - ov0, 0);
    chk({tag, "_busy_in_done"}, done_busy_err - db0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int scyc, i0, o0, d0, ovc0, bc0, b;
    bit ok;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    ram[0] = 32'd11; ram[1] = 32'd22; ram[2] = 32'd33; ram[3] = 32'd44;
    run_dump("basic", 0, 4, 0, 1'b1, 0);
    run_dump("stall", 0, 4, 1, 1'b1, 0);
    run_dump("wrap", 1022, 4, 0, 1'b1, 0);

    // zero-length request
    i0 = iss_addr_q.size(); d0 = done_cnt; ovc0 = ov_cyc_cnt; bc0 = busy_cyc_cnt;
    mode = 0;
    pulse_start(5, 0, scyc);
    wait_done(d0, 20, ok);
    chk("zero_done_seen", longint'(ok), 1);
    chk("zero_done_cyc", done_cyc, scyc + 1);
    repeat (3) @(negedge clk);
    chk("zero_done_count", done_cnt - d0, 1);
    chk("zero_issues", iss_addr_q.size() - i0, 0);
    chk("zero_out_valid", ov_cyc_cnt - ovc0, 0);
    chk("zero_busy", busy_cyc_cnt - bc0, 0);

    run_dump("restart_ignored", 0, 4, 1, 1'b0, 3);

    // reset in the middle of a dump with a full buffer
    b = 200;
    d0 = done_cnt;
    o0 = obs_addr_q.size();
    acc_limit = o0 + 2;
    mode = 3;
    pulse_start(b, 8, scyc);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (obs_addr_q.size() >= acc_limit) begin
        ok = 1'b1;
        break;
      end
    end
    chk("midrst_two_accepted", longint'(ok), 1);
    repeat (6) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    chk("midrst_valid_before", out_valid, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_ce", mem_ce, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_addr", out_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_dump("after_rst_full", b, DEPTH, 2, 1'b0, 0);

    // randomized dumps
    for (int t = 0; t < 6; t++) begin
      run_dump($sformatf("rand%0d", t), int'($urandom_range(0, DEPTH - 1)),
               (t == 0) ? 1 : int'($urandom_range(1, 40)), int'($urandom_range(0, 2)),
               1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
